arb_mux2: RTL

Two-input, packet-aware, round-robin arbitrated stream multiplexer: the combining counterpart of the 1-to-2 demultiplexer. It merges two valid/ready input streams (A, B) onto one output stream, never interleaving beats of a packet. A sideband select output tells downstream which input each beat came from, so a downstream demultiplexer can split the stream again. A one-entry output register breaks the ready/valid timing path and sustains one beat per cycle.

---
 rtl/arb_mux2_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 71 +++++++
 rtl/arb_mux2.sv | 68 ++++++
 3 files changed

// File: rtl/arb_mux2_pkg.sv
// Shared types and constants for the two-input packet arbiter/mux.
// Select encoding matches the companion 1-to-2 demultiplexer.
package arb_mux2_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Priority after a packet completes points at the other input.
    function automatic logic other_sel(input logic sel);
        return (sel == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Packet-aware round-robin arbiter for two streams.
// Ports: clock, reset_n, a/b valid+last, take (transfer strobe), grant_a/b.
module rr_arbiter2
    import arb_mux2_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic a_valid,
    input  logic a_last,
    input  logic b_valid,
    input  logic b_last,
    input  logic take,
    output logic grant_a,
    output logic grant_b
);

    arb_state_t state;
    arb_state_t state_next;
    logic       prio;
    logic       prio_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            prio  <= SEL_A;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        prio_next  = prio;

        // Grants only ever follow valid, so a grant always means a beat.
        unique case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a = (prio == SEL_A);
                    grant_b = (prio == SEL_B);
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
            LOCK_A: grant_a = a_valid;
            LOCK_B: grant_b = b_valid;
            default: ;
        endcase

        if (take && grant_a) begin
            if (a_last) begin
                state_next = IDLE;
                prio_next  = other_sel(SEL_A);
            end else begin
                state_next = LOCK_A;
            end
        end else if (take && grant_b) begin
            if (b_last) begin
                state_next = IDLE;
                prio_next  = other_sel(SEL_B);
            end else begin
                state_next = LOCK_B;
            end
        end
    end

endmodule

// File: rtl/arb_mux2.sv
// Two-input packet-aware round-robin stream mux with registered output.
// Ports: clock, reset_n, a_*/b_* input streams, y_* output stream + y_sel.
module arb_mux2
    import arb_mux2_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    output logic             y_sel,
    input  logic             y_ready
);

    logic load_en;
    logic take;
    logic grant_a;
    logic grant_b;

    assign load_en = !y_valid || y_ready;
    // Nothing is accepted while reset is held, so no beat is lost.
    assign take    = load_en && reset_n;
    assign a_ready = take && grant_a;
    assign b_ready = take && grant_b;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .a_valid (a_valid),
        .a_last  (a_last),
        .b_valid (b_valid),
        .b_last  (b_last),
        .take    (take),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
            y_sel   <= SEL_A;
        end else if (load_en) begin
            y_valid <= grant_a || grant_b;
            if (grant_a) begin
                y_data <= a_data;
                y_last <= a_last;
                y_sel  <= SEL_A;
            end else if (grant_b) begin
                y_data <= b_data;
                y_last <= b_last;
                y_sel  <= SEL_B;
            end
        end
    end

endmodule
